// File: rtl/rvic_pkg.sv
// Shared constants and enumerations for the RVIC claim core and its arbitration tree.
package rvic_pkg;

  localparam int RVIC_ID_OUT_W = 8;

  typedef enum logic {
    TRIG_LEVEL = 1'b0,
    TRIG_EDGE  = 1'b1
  } trig_mode_e;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_SETTLE = 1'b1
  } rvic_state_e;

endpackage

// File: rtl/rvic_max_tree.sv
// Pairwise max-priority tree: the highest priority among valid leaves wins.
// At every node a tie goes to the left child, which always holds the lower source indices.
module rvic_max_tree #(
  parameter  int N      = 32,
  parameter  int PRIO_W = 8,
  localparam int ID_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        valid_i,
  input  logic [N*PRIO_W-1:0] prio_i,
  output logic                valid_o,
  output logic [ID_W-1:0]     id_o,
  output logic [PRIO_W-1:0]   prio_o
);

  localparam int LVL    = (N > 1) ? $clog2(N) : 1;
  localparam int LEAVES = 1 << LVL;

  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    localparam int W = LEAVES >> l;
    logic [W-1:0]      v_s;
    logic [ID_W-1:0]   id_s [W];
    logic [PRIO_W-1:0] p_s  [W];

    if (l == 0) begin : g_leaves
      for (genvar g = 0; g < W; g++) begin : g_leaf
        if (g < N) begin : g_src
          assign v_s[g]  = valid_i[g];
          assign id_s[g] = ID_W'(g);
          assign p_s[g]  = prio_i[g*PRIO_W +: PRIO_W];
        end else begin : g_pad
          assign v_s[g]  = 1'b0;
          assign id_s[g] = {ID_W{1'b0}};
          assign p_s[g]  = {PRIO_W{1'b0}};
        end
      end
    end else begin : g_cmp
      for (genvar k = 0; k < W; k++) begin : g_node
        logic take_r_s;
        assign take_r_s = g_lvl[l-1].v_s[2*k+1] &
                          (~g_lvl[l-1].v_s[2*k] | (g_lvl[l-1].p_s[2*k+1] > g_lvl[l-1].p_s[2*k]));
        assign v_s[k]  = g_lvl[l-1].v_s[2*k] | g_lvl[l-1].v_s[2*k+1];
        assign id_s[k] = take_r_s ? g_lvl[l-1].id_s[2*k+1] : g_lvl[l-1].id_s[2*k];
        assign p_s[k]  = take_r_s ? g_lvl[l-1].p_s[2*k+1]  : g_lvl[l-1].p_s[2*k];
      end
    end
  end

  assign valid_o = g_lvl[LVL].v_s[0];
  assign id_o    = g_lvl[LVL].v_s[0] ? g_lvl[LVL].id_s[0] : {ID_W{1'b0}};
  assign prio_o  = g_lvl[LVL].v_s[0] ? g_lvl[LVL].p_s[0]  : {PRIO_W{1'b0}};

endmodule

// File: rtl/rvic_claim_core.sv
// Interrupt gateways, max-priority arbitration with threshold, and a claim/complete handshake
// that keeps a source from re-interrupting while it is in service.
module rvic_claim_core
  import rvic_pkg::*;
#(
  parameter int NUM_SRC = 32,
  parameter int PRIO_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC-1:0]        src_i,
  input  logic [NUM_SRC-1:0]        enable_i,
  input  logic [NUM_SRC-1:0]        edge_i,
  input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]         threshold_i,
  output logic                      irq_o,
  output logic [RVIC_ID_OUT_W-1:0]  irq_id_o,
  input  logic                      claim_i,
  output logic [RVIC_ID_OUT_W-1:0]  claim_id_o,
  input  logic                      complete_i,
  input  logic [RVIC_ID_OUT_W-1:0]  complete_id_i,
  output logic [NUM_SRC-1:0]        pending_o,
  output logic [NUM_SRC-1:0]        inservice_o
);

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [NUM_SRC-1:0] SRC0_V = {{(NUM_SRC-1){1'b0}}, 1'b1};
  localparam logic [NUM_SRC-1:0] ZERO_V = {NUM_SRC{1'b0}};

  logic [NUM_SRC-1:0]       src_q_r, pending_r, inservice_r;
  logic                     irq_r;
  logic [RVIC_ID_OUT_W-1:0] irq_id_r;
  rvic_state_e              state_r, state_nxt_s;

  logic [NUM_SRC-1:0] trig_s, prio_gt_s, pend_set_s, eligible_s;
  logic [NUM_SRC-1:0] claim_vec_s, complete_vec_s, pending_nxt_s, inservice_nxt_s;
  logic               claim_acc_s, complete_ok_s, irq_nxt_s, tree_valid_s;
  logic [ID_W-1:0]    tree_id_s;
  logic [PRIO_W-1:0]  tree_prio_s;
  logic [RVIC_ID_OUT_W-1:0] irq_id_nxt_s;

  // Per-source trigger detection and priority-over-threshold compare
  always_comb begin
    trig_s    = ZERO_V;
    prio_gt_s = ZERO_V;
    for (int n = 0; n < NUM_SRC; n++) begin
      if (trig_mode_e'(edge_i[n]) == TRIG_EDGE) begin
        trig_s[n] = src_i[n] & ~src_q_r[n];
      end else begin
        trig_s[n] = src_i[n];
      end
      prio_gt_s[n] = prio_i[n*PRIO_W +: PRIO_W] > threshold_i;
    end
  end

  assign claim_acc_s   = claim_i & irq_r;
  assign claim_vec_s   = claim_acc_s ? (SRC0_V << irq_id_r) : ZERO_V;
  assign complete_ok_s = complete_i && (complete_id_i != 8'd0) &&
                         (32'(complete_id_i) < 32'(NUM_SRC));
  assign complete_vec_s = complete_ok_s ? (SRC0_V << complete_id_i) : ZERO_V;

  // A level source being claimed this cycle is the interrupt being serviced, so it must not re-pend.
  assign pend_set_s = trig_s & enable_i & (edge_i | ~(inservice_r | claim_vec_s)) & ~SRC0_V;

  // Level triggers feed arbitration in the same cycle they are seen; edges go through pending first.
  assign eligible_s = (pending_r | (pend_set_s & ~edge_i)) & enable_i & ~inservice_r &
                      prio_gt_s & ~SRC0_V;

  assign pending_nxt_s   = (pending_r & ~claim_vec_s) | pend_set_s;
  assign inservice_nxt_s = ((inservice_r & ~complete_vec_s) | claim_vec_s) & ~SRC0_V;

  rvic_max_tree #(
    .N      (NUM_SRC),
    .PRIO_W (PRIO_W)
  ) u_tree (
    .valid_i (eligible_s),
    .prio_i  (prio_i),
    .valid_o (tree_valid_s),
    .id_o    (tree_id_s),
    .prio_o  (tree_prio_s)
  );

  // Handshake FSM: present the winner in ARB, blank the output for one cycle after a claim
  always_comb begin
    state_nxt_s  = ST_ARB;
    irq_nxt_s    = 1'b0;
    irq_id_nxt_s = 8'd0;
    case (state_r)
      ST_ARB: begin
        if (claim_acc_s) begin
          state_nxt_s = ST_SETTLE;
        end else if (tree_valid_s && (tree_prio_s > threshold_i)) begin
          irq_nxt_s    = 1'b1;
          irq_id_nxt_s = RVIC_ID_OUT_W'(tree_id_s);
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_SETTLE: begin
        state_nxt_s = ST_ARB;
      end
      default: begin
        state_nxt_s = ST_ARB;
      end
    endcase
  end

  // State, gateway history and registered interrupt outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_ARB;
      src_q_r     <= ZERO_V;
      pending_r   <= ZERO_V;
      inservice_r <= ZERO_V;
      irq_r       <= 1'b0;
      irq_id_r    <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      src_q_r     <= src_i & ~SRC0_V;
      pending_r   <= pending_nxt_s;
      inservice_r <= inservice_nxt_s;
      irq_r       <= irq_nxt_s;
      irq_id_r    <= irq_id_nxt_s;
    end
  end

  assign irq_o       = irq_r;
  assign irq_id_o    = irq_id_r;
  assign claim_id_o  = claim_acc_s ? irq_id_r : 8'd0;
  assign pending_o   = pending_r;
  assign inservice_o = inservice_r;

endmodule

// File: tb/tb_rvic_claim_core.sv
// Self-checking bench for rvic_claim_core: directed scenarios plus randomized traffic
// compared against a source-by-source behavioural model.
module tb_rvic_claim_core;

  localparam int NS = 32;
  localparam int PW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src, en, edg;
  logic [NS*PW-1:0] prio_v;
  logic [PW-1:0]    thr;
  logic             claim, cmpl;
  logic [7:0]       cid;
  logic             irq;
  logic [7:0]       irq_id, claim_id;
  logic [NS-1:0]    pend, insv;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit m_pend [NS];
  bit m_insv [NS];
  bit m_prev [NS];
  bit m_irq;
  bit m_settle;
  int m_id;

  always #5 clk = ~clk;

  rvic_claim_core #(.NUM_SRC(NS), .PRIO_W(PW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .src_i         (src),
    .enable_i      (en),
    .edge_i        (edg),
    .prio_i        (prio_v),
    .threshold_i   (thr),
    .irq_o         (irq),
    .irq_id_o      (irq_id),
    .claim_i       (claim),
    .claim_id_o    (claim_id),
    .complete_i    (cmpl),
    .complete_id_i (cid),
    .pending_o     (pend),
    .inservice_o   (insv)
  );

  function automatic logic [NS-1:0] pack(input bit a [NS]);
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic int pr(input int n);
    return int'(prio_v[n*PW +: PW]);
  endfunction

  // One clock edge of the reference behaviour, using the inputs currently applied.
  task automatic model_step();
    bit nset [NS];
    bit acc, trig;
    int best, bp, clr;
    if (rst) begin
      for (int n = 0; n < NS; n++) begin
        m_pend[n] = 1'b0; m_insv[n] = 1'b0; m_prev[n] = 1'b0;
      end
      m_irq = 1'b0; m_id = 0; m_settle = 1'b0;
      return;
    end
    acc = claim && m_irq;
    clr = acc ? m_id : -1;
    best = -1; bp = -1;
    for (int n = 0; n < NS; n++) begin
      trig = edg[n] ? (src[n] && !m_prev[n]) : src[n];
      nset[n] = (n != 0) && trig && en[n] && (edg[n] || (!m_insv[n] && n != clr));
      if (n != 0 && en[n] && !m_insv[n] && pr(n) > int'(thr) &&
          (m_pend[n] || (nset[n] && !edg[n])) && pr(n) > bp) begin
        best = n; bp = pr(n);
      end
    end
    if (cmpl && cid != 8'd0 && int'(cid) < NS) m_insv[cid] = 1'b0;
    for (int n = 0; n < NS; n++) begin
      m_pend[n] = nset[n] || (m_pend[n] && n != clr);
      m_prev[n] = src[n];
    end
    if (acc) m_insv[clr] = 1'b1;
    if (m_settle || acc || best < 0) begin
      m_irq = 1'b0; m_id = 0;
    end else begin
      m_irq = 1'b1; m_id = best;
    end
    m_settle = acc;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int n, input int p);
    prio_v[n*PW +: PW] = PW'(p);
  endtask

  task automatic do_reset();
    src = '0; en = '0; edg = '0; prio_v = '0; thr = 8'd0;
    claim = 1'b0; cmpl = 1'b0; cid = 8'd0;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic claim_now();
    claim = 1'b1; cycle(); claim = 1'b0;
  endtask

  task automatic complete(input int id);
    cmpl = 1'b1; cid = 8'(id); cycle(); cmpl = 1'b0; cid = 8'd0;
  endtask

  task automatic wait_irq(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (irq === 1'b1) begin ok = 1'b1; break; end
      cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; src = $urandom; en = $urandom; edg = $urandom; thr = 8'd0;
    claim = 1'b0; cmpl = 1'b0; cid = 8'd0;
    for (int n = 0; n < NS; n++) set_prio(n, $urandom_range(1, 9));
    cycle(); cycle();
    checks++; if (irq !== 1'b0 || irq_id !== 8'd0) begin errors++; $display("FAIL reset_irq: got irq=%0b id=%0d expected 0/0", irq, irq_id); end
    checks++; if (pend !== '0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pend); end
    checks++; if (insv !== '0) begin errors++; $display("FAIL reset_inservice: got %h expected 0", insv); end
    do_reset();
  endtask

  task automatic test_level_basic();
    do_reset();
    en[5] = 1'b1; set_prio(5, 3); src[5] = 1'b1;
    cycle();
    checks++; if (irq !== 1'b1 || irq_id !== 8'd5) begin errors++; $display("FAIL level_latency: got irq=%0b id=%0d expected 1/5", irq, irq_id); end
    claim = 1'b1; #1;
    checks++; if (claim_id !== 8'd5) begin errors++; $display("FAIL level_claim_id: got %0d expected 5", claim_id); end
    cycle(); claim = 1'b0;
    checks++; if (irq !== 1'b0 || insv[5] !== 1'b1 || pend[5] !== 1'b0) begin errors++; $display("FAIL level_after_claim: got irq=%0b insv=%0b pend=%0b expected 0/1/0", irq, insv[5], pend[5]); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_in_service: got irq=%0b expected 0", irq); end
    end
    src[5] = 1'b0;
    complete(5);
    checks++; if (insv[5] !== 1'b0) begin errors++; $display("FAIL level_complete: got insv=%0b expected 0", insv[5]); end
    cycle(); cycle();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_quiet: got irq=%0b expected 0", irq); end
  endtask

  task automatic test_priority_tie();
    bit ok;
    do_reset();
    en[4] = 1'b1; en[9] = 1'b1; en[12] = 1'b1;
    set_prio(4, 7); set_prio(9, 7); set_prio(12, 2);
    src[4] = 1'b1; src[9] = 1'b1; src[12] = 1'b1;
    cycle();
    checks++; if (irq_id !== 8'd4) begin errors++; $display("FAIL tie_lowest_id: got %0d expected 4", irq_id); end
    claim = 1'b1; src[4] = 1'b0; cycle(); claim = 1'b0;
    complete(4);
    wait_irq(6, ok);
    checks++; if (!ok || irq_id !== 8'd9) begin errors++; $display("FAIL tie_second: got irq=%0b id=%0d expected 1/9", irq, irq_id); end
    claim_now();
    wait_irq(6, ok);
    checks++; if (!ok || irq_id !== 8'd12) begin errors++; $display("FAIL tie_third: got irq=%0b id=%0d expected 1/12", irq, irq_id); end
  endtask

  task automatic test_edge_merge();
    bit ok, quiet;
    do_reset();
    en[3] = 1'b1; edg[3] = 1'b1; set_prio(3, 4);
    src[3] = 1'b1; cycle(); src[3] = 1'b0;
    checks++; if (irq !== 1'b0 || pend[3] !== 1'b1) begin errors++; $display("FAIL edge_latency: got irq=%0b pend=%0b expected 0/1", irq, pend[3]); end
    wait_irq(5, ok);
    checks++; if (!ok || irq_id !== 8'd3) begin errors++; $display("FAIL edge_first: got irq=%0b id=%0d expected 1/3", irq, irq_id); end
    claim_now();
    for (int i = 0; i < 2; i++) begin
      src[3] = 1'b1; cycle(); src[3] = 1'b0; cycle();
    end
    checks++; if (pend[3] !== 1'b1 || insv[3] !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL edge_merged: got pend=%0b insv=%0b irq=%0b expected 1/1/0", pend[3], insv[3], irq); end
    complete(3);
    wait_irq(5, ok);
    checks++; if (!ok || irq_id !== 8'd3) begin errors++; $display("FAIL edge_reirq: got irq=%0b id=%0d expected 1/3", irq, irq_id); end
    claim_now();
    complete(3);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (irq !== 1'b0) quiet = 1'b0;
      cycle();
    end
    checks++; if (!quiet) begin errors++; $display("FAIL edge_single: got extra irq id=%0d expected none", irq_id); end
  endtask

  task automatic test_threshold();
    do_reset();
    thr = 8'd5; en[10] = 1'b1; set_prio(10, 5); src[10] = 1'b1;
    cycle(); cycle(); cycle();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_equal_masked: got irq=%0b expected 0", irq); end
    set_prio(10, 6);
    cycle();
    checks++; if (irq !== 1'b1 || irq_id !== 8'd10) begin errors++; $display("FAIL thr_above: got irq=%0b id=%0d expected 1/10", irq, irq_id); end
  endtask

  task automatic test_edge_during_claim();
    bit ok;
    do_reset();
    en[7] = 1'b1; edg[7] = 1'b1; set_prio(7, 2);
    src[7] = 1'b1; cycle(); src[7] = 1'b0;
    wait_irq(5, ok);
    checks++; if (!ok || irq_id !== 8'd7) begin errors++; $display("FAIL edc_first: got irq=%0b id=%0d expected 1/7", irq, irq_id); end
    claim = 1'b1; src[7] = 1'b1; cycle(); claim = 1'b0; src[7] = 1'b0;
    checks++; if (pend[7] !== 1'b1 || insv[7] !== 1'b1) begin errors++; $display("FAIL edc_set_wins: got pend=%0b insv=%0b expected 1/1", pend[7], insv[7]); end
    cycle();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edc_masked: got irq=%0b expected 0", irq); end
    complete(7);
    wait_irq(5, ok);
    checks++; if (!ok || irq_id !== 8'd7) begin errors++; $display("FAIL edc_reirq: got irq=%0b id=%0d expected 1/7", irq, irq_id); end
  endtask

  task automatic test_bogus();
    do_reset();
    en = '1;
    for (int n = 0; n < NS; n++) set_prio(n, 5);
    src = 32'h1;
    cycle(); cycle(); cycle();
    checks++; if (irq !== 1'b0 || pend !== '0) begin errors++; $display("FAIL src0_ignored: got irq=%0b pend=%h expected 0/0", irq, pend); end
    claim = 1'b1; #1;
    checks++; if (claim_id !== 8'd0) begin errors++; $display("FAIL claim_idle_id: got %0d expected 0", claim_id); end
    cycle(); claim = 1'b0;
    src = 32'h4;
    cycle();
    checks++; if (irq !== 1'b1 || irq_id !== 8'd2) begin errors++; $display("FAIL bogus_src2: got irq=%0b id=%0d expected 1/2", irq, irq_id); end
    claim_now();
    complete(200);
    complete(0);
    checks++; if (insv !== 32'h4) begin errors++; $display("FAIL bogus_complete: got %h expected 00000004", insv); end
    src = '0; rst = 1'b1; cycle(); rst = 1'b0; cycle();
    checks++; if (irq !== 1'b0 || pend !== '0 || insv !== '0) begin errors++; $display("FAIL reset_mid_service: got irq=%0b pend=%h insv=%h expected 0", irq, pend, insv); end
  endtask

  task automatic test_random();
    logic [7:0] exp_cid;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) begin
        en = $urandom; edg = $urandom; thr = 8'($urandom_range(0, 3));
        for (int n = 0; n < NS; n++) set_prio(n, $urandom_range(0, 7));
      end
      src   = $urandom & $urandom & $urandom;
      claim = ($urandom_range(0, 2) == 0);
      cmpl  = ($urandom_range(0, 2) == 0);
      cid   = 8'($urandom_range(0, 40));
      rst   = ($urandom_range(0, 149) == 0);
      #1;
      exp_cid = (claim && m_irq) ? 8'(m_id) : 8'd0;
      checks++; if (claim_id !== exp_cid) begin errors++; $display("FAIL rnd_claim_id c=%0d: got %0d expected %0d", c, claim_id, exp_cid); end
      cycle();
      checks++; if (irq !== m_irq || irq_id !== 8'(m_id)) begin errors++; $display("FAIL rnd_irq c=%0d: got %0b/%0d expected %0b/%0d", c, irq, irq_id, m_irq, m_id); end
      checks++; if (pend !== pack(m_pend)) begin errors++; $display("FAIL rnd_pending c=%0d: got %h expected %h", c, pend, pack(m_pend)); end
      checks++; if (insv !== pack(m_insv)) begin errors++; $display("FAIL rnd_inservice c=%0d: got %h expected %h", c, insv, pack(m_insv)); end
    end
    rst = 1'b0; claim = 1'b0; cmpl = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level_basic();
    test_priority_tie();
    test_edge_merge();
    test_threshold();
    test_edge_during_claim();
    test_bogus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
